// File: rtl/alarm_ctrl_pkg.sv
// Shared types and select encodings for the alarm clock mode controller.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_CLOCK  = 2'd0,
        ST_ADJUST = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        F_CLK_HR  = 2'd0,
        F_CLK_MIN = 2'd1,
        F_ALM_HR  = 2'd2,
        F_ALM_MIN = 2'd3
    } field_t;

    localparam logic [1:0] SEL_MINS  = 2'b11;
    localparam logic [1:0] SEL_HOURS = 2'b10;
    localparam logic [1:0] SEL_NONE  = 2'b00;

    // Adjust fields form a ring of four; fwd=1 steps toward ALM_MIN, wrapping.
    function automatic field_t field_step(input field_t f, input logic fwd);
        logic [1:0] v;
        v = f;
        v = fwd ? v + 2'd1 : v - 2'd1;
        return field_t'(v);
    endfunction

endpackage

// File: rtl/alarm_match_detect.sv
// Alarm compare: equality of time and alarm setting gated by the arm switch,
// with a one-cycle pulse on the rising edge of the match condition.
module alarm_match_detect (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_on,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_mins,
    input  logic [4:0] alm_hours,
    input  logic [5:0] alm_mins,
    output logic       match_rise
);

    logic match;
    logic match_prev;

    assign match = alarm_on && (cur_hours == alm_hours) && (cur_mins == alm_mins);

    // Tracked in every controller state so a match that began while adjusting
    // does not look like a fresh edge once the clock resumes.
    always_ff @(posedge clk) begin
        if (rst) match_prev <= 1'b0;
        else     match_prev <= match;
    end

    assign match_rise = match & ~match_prev;

endmodule

// File: rtl/alarm_mode_controller.sv
// Alarm clock mode/sequence controller: adjust commands, display select, ring cycle.
// Optional snooze state is built when ALARM_SNOOZE_EN is defined.
module alarm_mode_controller #(
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       alarm_on,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_mins,
    input  logic [4:0] alm_hours,
    input  logic [5:0] alm_mins,
    output logic       clock_run,
    output logic [1:0] clk_sel,
    output logic [1:0] alm_sel,
    output logic       adj_pulse,
    output logic       up_down,
    output logic       display_sel,
    output logic [3:0] field_leds,
    output logic       buzzer
);
    import alarm_ctrl_pkg::*;

    // Ring and snooze never overlap, so one seconds counter serves both.
    localparam int CW = $clog2(((RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS) + 1);
    localparam logic [CW-1:0] RING_LAST = CW'(RING_TICKS - 1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [CW-1:0] SNZ_LAST  = CW'(SNOOZE_TICKS - 1);
`endif

    state_t        state, state_nx;
    field_t        field, field_nx;
    logic [CW-1:0] tcnt, tcnt_nx;
    logic          match_rise;

    logic       adj_nx, up_down_nx, clock_run_nx, display_sel_nx, buzzer_nx;
    logic [1:0] clk_sel_nx, alm_sel_nx;
    logic [3:0] field_leds_nx;

    alarm_match_detect u_match (
        .clk        (clk),
        .rst        (rst),
        .alarm_on   (alarm_on),
        .cur_hours  (cur_hours),
        .cur_mins   (cur_mins),
        .alm_hours  (alm_hours),
        .alm_mins   (alm_mins),
        .match_rise (match_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLOCK;
            field       <= F_CLK_HR;
            tcnt        <= '0;
            clock_run   <= 1'b1;
            clk_sel     <= SEL_NONE;
            alm_sel     <= SEL_NONE;
            adj_pulse   <= 1'b0;
            up_down     <= 1'b1;
            display_sel <= 1'b0;
            field_leds  <= 4'b0000;
            buzzer      <= 1'b0;
        end else begin
            state       <= state_nx;
            field       <= field_nx;
            tcnt        <= tcnt_nx;
            clock_run   <= clock_run_nx;
            clk_sel     <= clk_sel_nx;
            alm_sel     <= alm_sel_nx;
            adj_pulse   <= adj_nx;
            up_down     <= up_down_nx;
            display_sel <= display_sel_nx;
            field_leds  <= field_leds_nx;
            buzzer      <= buzzer_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        field_nx   = field;
        tcnt_nx    = tcnt;
        adj_nx     = 1'b0;
        up_down_nx = up_down;
        case (state)
            ST_CLOCK: begin
                if (match_rise) begin
                    state_nx = ST_RING;
                    tcnt_nx  = '0;
                end else if (btn_c) begin
                    state_nx = ST_ADJUST;
                    field_nx = F_CLK_HR;
                end
            end
            ST_ADJUST: begin
                if (btn_r && !btn_l)      field_nx = field_step(field, 1'b1);
                else if (btn_l && !btn_r) field_nx = field_step(field, 1'b0);
                // No count pulse on the exit cycle: the selects drop to none then.
                if (btn_c) begin
                    state_nx = ST_CLOCK;
                end else if (btn_u ^ btn_d) begin
                    adj_nx     = 1'b1;
                    up_down_nx = btn_u;
                end
            end
            ST_RING: begin
                if (!alarm_on || btn_c) begin
                    state_nx = ST_CLOCK;
`ifdef ALARM_SNOOZE_EN
                end else if (btn_u || btn_d) begin
                    state_nx = ST_SNOOZE;
                    tcnt_nx  = '0;
`endif
                end else if (tick_1hz) begin
                    if (tcnt == RING_LAST) state_nx = ST_CLOCK;
                    else                   tcnt_nx  = tcnt + 1'b1;
                end
            end
            ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                if (!alarm_on || btn_c) begin
                    state_nx = ST_CLOCK;
                end else if (tick_1hz) begin
                    if (tcnt == SNZ_LAST) begin
                        state_nx = ST_RING;
                        tcnt_nx  = '0;
                    end else begin
                        tcnt_nx  = tcnt + 1'b1;
                    end
                end
`else
                state_nx = ST_CLOCK;
`endif
            end
            default: state_nx = ST_CLOCK;
        endcase
    end

    // Decoded from the next state so every output lands with its cause.
    always_comb begin
        clock_run_nx   = 1'b1;
        clk_sel_nx     = SEL_NONE;
        alm_sel_nx     = SEL_NONE;
        display_sel_nx = 1'b0;
        field_leds_nx  = 4'b0000;
        buzzer_nx      = (state_nx == ST_RING);
        if (state_nx == ST_ADJUST) begin
            clock_run_nx = 1'b0;
            case (field_nx)
                F_CLK_HR:  clk_sel_nx = SEL_HOURS;
                F_CLK_MIN: clk_sel_nx = SEL_MINS;
                F_ALM_HR:  alm_sel_nx = SEL_HOURS;
                default:   alm_sel_nx = SEL_MINS;
            endcase
            display_sel_nx = (field_nx == F_ALM_HR) || (field_nx == F_ALM_MIN);
            field_leds_nx  = 4'b0001 << field_nx;
        end
    end

endmodule
